// File: rtl/lag_pkg.sv
// Shared types and widths for the display-lag measurement sequencer.
package lag_pkg;

    localparam int LAT_W    = 24;
    localparam int SUM_W    = 29;
    localparam int MAX_LOG2 = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FLASH,
        RECOVER,
        FINISH
    } state_e;

endpackage

// File: rtl/sensor_sync.sv
// Multi-flop synchronizer that brings the asynchronous photosensor into the clk domain.
module sensor_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/lag_sequencer.sv
// Flashes a white patch, times how long the photosensor takes to see it, and
// accumulates last/min/max/average latency over a run of 2^k samples.
module lag_sequencer
    import lag_pkg::*;
#(
    parameter logic [LAT_W-1:0] TIMEOUT     = 24'hFFFFFF,
    parameter int               GAP_FRAMES  = 2,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       samples_log2,
    input  logic             vblank_start,
    input  logic             sensor,
    output logic             flash,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [4:0]       sample_idx,
    output logic [LAT_W-1:0] lat_last,
    output logic [LAT_W-1:0] lat_min,
    output logic [LAT_W-1:0] lat_max,
    output logic [LAT_W-1:0] lat_avg
);

    localparam logic [7:0]       GAP_LAST = 8'(GAP_FRAMES - 1);
    localparam logic [LAT_W-1:0] MIN_INIT = '1;

    logic sensor_s;

    sensor_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (sensor),
        .dout   (sensor_s)
    );

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         gap_q, gap_d;
    logic [2:0]         k_q, k_d;
    logic [4:0]         idx_q, idx_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [LAT_W-1:0]   last_q, last_d;
    logic [LAT_W-1:0]   min_q, min_d;
    logic [LAT_W-1:0]   max_q, max_d;
    logic [LAT_W-1:0]   avg_q, avg_d;
    logic               timeout_q, timeout_d;
    logic               flash_q, flash_d;
    logic               done_q, done_d;
    logic [4:0]         n_target;

    assign n_target = 5'd1 << k_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        k_d       = k_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        last_d    = last_q;
        min_d     = min_q;
        max_d     = max_q;
        avg_d     = avg_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;

        // abort outranks everything, including a simultaneous start or sensor hit
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = ARM;
                        idx_d     = '0;
                        sum_d     = '0;
                        min_d     = MIN_INIT;
                        max_d     = '0;
                        timeout_d = 1'b0;
                        k_d       = (samples_log2 > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : samples_log2;
                    end
                end
                ARM: begin
                    if (vblank_start && !sensor_s) begin
                        state_d = FLASH;
                        cnt_d   = '0;
                    end
                end
                FLASH: begin
                    if (sensor_s) begin
                        last_d  = cnt_q;
                        sum_d   = sum_q + SUM_W'(cnt_q);
                        min_d   = (idx_q == 5'd0 || cnt_q < min_q) ? cnt_q : min_q;
                        max_d   = (idx_q == 5'd0 || cnt_q > max_q) ? cnt_q : max_q;
                        idx_d   = idx_q + 5'd1;
                        gap_d   = '0;
                        state_d = RECOVER;
                    end else if (cnt_q == TIMEOUT) begin
                        timeout_d = 1'b1;
                        state_d   = FINISH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RECOVER: begin
                    // a vblank seen while the patch is still lit does not count toward the gap
                    if (vblank_start && !sensor_s) begin
                        if (gap_q == GAP_LAST) begin
                            state_d = (idx_q < n_target) ? ARM : FINISH;
                        end else begin
                            gap_d = gap_q + 8'd1;
                        end
                    end
                end
                FINISH: begin
                    if (!timeout_q) begin
                        avg_d = LAT_W'(sum_q >> k_q);
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        flash_d = (state_d == FLASH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            k_q       <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            last_q    <= '0;
            min_q     <= MIN_INIT;
            max_q     <= '0;
            avg_q     <= '0;
            timeout_q <= 1'b0;
            flash_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            k_q       <= k_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            last_q    <= last_d;
            min_q     <= min_d;
            max_q     <= max_d;
            avg_q     <= avg_d;
            timeout_q <= timeout_d;
            flash_q   <= flash_d;
            done_q    <= done_d;
        end
    end

    assign flash      = flash_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign sample_idx = idx_q;
    assign lat_last   = last_q;
    assign lat_min    = min_q;
    assign lat_max    = max_q;
    assign lat_avg    = avg_q;

endmodule

// File: tb/tb_lag_sequencer.sv
// Directed bench for lag_sequencer: run results are queued at start and checked on done.
`timescale 1ns/1ps
module tb_lag_sequencer;

    localparam int SYNC = 2;
    localparam int GAP  = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, start_to, abort;
    logic [2:0]  samples_log2;
    logic        vblank_start, sensor;

    logic        flash, busy, done, timeout;
    logic [4:0]  sample_idx;
    logic [23:0] lat_last, lat_min, lat_max, lat_avg;

    logic        flash_to, busy_to, done_to, timeout_to;
    logic [4:0]  sample_idx_to;
    logic [23:0] lat_last_to, lat_min_to, lat_max_to, lat_avg_to;

    always #5 clk = ~clk;

    lag_sequencer #(.TIMEOUT(24'hFFFFFF), .GAP_FRAMES(GAP), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .samples_log2(samples_log2), .vblank_start(vblank_start), .sensor(sensor),
        .flash(flash), .busy(busy), .done(done), .timeout(timeout),
        .sample_idx(sample_idx), .lat_last(lat_last), .lat_min(lat_min),
        .lat_max(lat_max), .lat_avg(lat_avg)
    );

    lag_sequencer #(.TIMEOUT(24'd500), .GAP_FRAMES(GAP), .SYNC_STAGES(SYNC)) dut_to (
        .clk(clk), .reset_n(reset_n), .start(start_to), .abort(abort),
        .samples_log2(samples_log2), .vblank_start(vblank_start), .sensor(sensor),
        .flash(flash_to), .busy(busy_to), .done(done_to), .timeout(timeout_to),
        .sample_idx(sample_idx_to), .lat_last(lat_last_to), .lat_min(lat_min_to),
        .lat_max(lat_max_to), .lat_avg(lat_avg_to)
    );

    typedef struct packed {
        logic [23:0] last;
        logic [23:0] min;
        logic [23:0] max;
        logic [23:0] avg;
        logic [4:0]  idx;
        logic        to;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_done = 0;
    int   lats[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: latency seen by the DUT is the drive delay plus the synchronizer depth.
    function automatic exp_t model(input int delays[$], input int k);
        exp_t e;
        int   s  = 0;
        int   mn = 32'hFFFFFF;
        int   mx = 0;
        int   l;
        foreach (delays[i]) begin
            l = delays[i] + SYNC;
            s += l;
            if (l < mn) mn = l;
            if (l > mx) mx = l;
        end
        e.last = 24'(delays[delays.size()-1] + SYNC);
        e.min  = 24'(mn);
        e.max  = 24'(mx);
        e.avg  = 24'(s >> k);
        e.idx  = 5'(delays.size());
        e.to   = 1'b0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset_n && done) begin
            n_done++;
            chk("done_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e_mon = sb.pop_front();
                chk("sb_lat_last", lat_last, e_mon.last);
                chk("sb_lat_min", lat_min, e_mon.min);
                chk("sb_lat_max", lat_max, e_mon.max);
                chk("sb_lat_avg", lat_avg, e_mon.avg);
                chk("sb_sample_idx", sample_idx, e_mon.idx);
                chk("sb_timeout", timeout, e_mon.to);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [2:0] k);
        samples_log2 = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic pulse_vblank();
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
    endtask

    // From ARM: flash, light the sensor d cycles into FLASH, then give 'gaps' dark vblanks.
    task automatic run_sample(input int d, input int gaps);
        int n;
        sensor = 1'b0;
        repeat (3) tick();
        pulse_vblank();
        chk("flash_on", flash, 1);
        repeat (d) tick();
        sensor = 1'b1;
        n = 0;
        while (flash && n < 20) begin
            tick();
            n++;
        end
        chk("flash_off_after_hit", flash, 0);
        chk("lat_last", lat_last, 32'(d + SYNC));
        sensor = 1'b0;
        repeat (3) tick();
        for (int g = 0; g < gaps; g++) begin
            pulse_vblank();
            tick();
        end
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (n_done < target && n < 20) begin
            tick();
            n++;
        end
        chk("done_count", n_done, target);
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0; start = 1'b0; start_to = 1'b0; abort = 1'b0;
        samples_log2 = 3'd0; vblank_start = 1'b0; sensor = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flash", flash, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_sample_idx", sample_idx, 0);
        chk("rst_lat_last", lat_last, 0);
        chk("rst_lat_min", lat_min, 32'hFFFFFF);
        chk("rst_lat_max", lat_max, 0);
        chk("rst_lat_avg", lat_avg, 0);
        reset_n = 1'b1;
        repeat (2) tick();
        chk("idle_no_start", busy, 0);

        // single sample, k=0
        lats = '{1000};
        sb.push_back(model(lats, 0));
        start_run(3'd0);
        run_sample(1000, GAP);
        wait_done(1);

        // four samples, k=2, with an ignored start mid-run
        lats = '{100, 200, 300, 401};
        sb.push_back(model(lats, 2));
        start_run(3'd2);
        run_sample(100, GAP);
        samples_log2 = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_while_busy_busy", busy, 1);
        chk("start_while_busy_idx", sample_idx, 1);
        run_sample(200, GAP);
        run_sample(300, GAP);
        run_sample(401, GAP);
        wait_done(2);

        // frames skipped while the sensor is already lit
        lats = '{50};
        sb.push_back(model(lats, 0));
        sensor = 1'b1;
        repeat (3) tick();
        start_run(3'd0);
        for (int i = 0; i < 3; i++) begin
            pulse_vblank();
            tick();
            chk("arm_skip_flash", flash, 0);
            chk("arm_skip_busy", busy, 1);
        end
        run_sample(50, GAP);
        wait_done(3);

        // lost sample on the TIMEOUT=500 instance
        samples_log2 = 3'd0;
        start_to = 1'b1;
        tick();
        start_to = 1'b0;
        chk("to_busy", busy_to, 1);
        sensor = 1'b0;
        repeat (3) tick();
        pulse_vblank();
        n = 0;
        while (flash_to && n < 2000) begin
            tick();
            n++;
        end
        chk("to_flash_cycles", n, 501);
        chk("to_timeout_flag", timeout_to, 1);
        chk("to_busy_in_finish", busy_to, 1);
        tick();
        chk("to_done", done_to, 1);
        chk("to_idle", busy_to, 0);
        chk("to_sample_idx", sample_idx_to, 0);
        chk("to_lat_avg_stale", lat_avg_to, 0);
        tick();
        chk("to_done_one_cycle", done_to, 0);
        chk("main_untouched", busy, 0);

        // abort with simultaneous start, 10 cycles into FLASH
        start_run(3'd0);
        repeat (3) tick();
        pulse_vblank();
        repeat (10) tick();
        chk("abort_pre_flash", flash, 1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_flash", flash, 0);
        chk("abort_done", done, 0);
        repeat (5) tick();
        chk("abort_no_new_run", busy, 0);
        chk("abort_keeps_last", lat_last, 52);
        chk("abort_no_done_count", n_done, 3);

        // asynchronous reset in RECOVER, then a clean run
        start_run(3'd1);
        run_sample(20, 1);
        chk("rec_busy", busy, 1);
        chk("rec_idx", sample_idx, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_flash", flash, 0);
        chk("arst_sample_idx", sample_idx, 0);
        chk("arst_lat_last", lat_last, 0);
        chk("arst_lat_min", lat_min, 32'hFFFFFF);
        chk("arst_lat_avg", lat_avg, 0);
        chk("arst_timeout_to", timeout_to, 0);
        #1;
        reset_n = 1'b1;
        tick();
        chk("arst_no_done", n_done, 3);
        lats = '{30};
        sb.push_back(model(lats, 0));
        start_run(3'd0);
        run_sample(30, GAP);
        wait_done(4);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
